// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared packet layout, FSM encoding and RS class constants
package dispatch_pkg;

  localparam int PKT_W = 68;

  // Field offsets (LSB positions) and widths, MSB to LSB:
  // opcode, funct3, funct7, rs1, rs2, rd, imm, hasImm, regWrite, memRead, memWrite
  localparam int MEMWRITE_BIT = 0;
  localparam int MEMREAD_BIT  = 1;
  localparam int REGWRITE_BIT = 2;
  localparam int HASIMM_BIT   = 3;
  localparam int IMM_LSB      = 4;
  localparam int IMM_W        = 32;
  localparam int RD_LSB       = 36;
  localparam int RS2_LSB      = 41;
  localparam int RS1_LSB      = 46;
  localparam int REG_W        = 5;
  localparam int FUNCT7_LSB   = 51;
  localparam int FUNCT7_W     = 7;
  localparam int FUNCT3_LSB   = 58;
  localparam int FUNCT3_W     = 3;
  localparam int OPCODE_LSB   = 61;
  localparam int OPCODE_W     = 7;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } disp_state_t;

  typedef enum logic {
    RS_ALU = 1'b0,
    RS_LSU = 1'b1
  } rs_class_t;

  // Any memory access goes to the LSU; everything else, branches included, to the ALU.
  function automatic rs_class_t classify(input logic mem_read, input logic mem_write);
    return (mem_read | mem_write) ? RS_LSU : RS_ALU;
  endfunction

endpackage

// File: rtl/dispatch_scheduler_if.sv
// rtl/dispatch_scheduler_if.sv - decode, ROB and reservation-station handshake bundle
interface dispatch_scheduler_if #(
  parameter int PKT_W = 68,
  parameter int TAG_W = 4
);
  logic             dec_valid;
  logic             dec_ready;
  logic [PKT_W-1:0] dec_pkt;
  logic             rob_ready;
  logic [TAG_W-1:0] rob_tag;
  logic             rob_alloc;
  logic             alu_rs_ready;
  logic             alu_rs_valid;
  logic             lsu_rs_ready;
  logic             lsu_rs_valid;
  logic [PKT_W-1:0] disp_pkt;
  logic [TAG_W-1:0] disp_tag;

  // Environment side: decode, ROB and stations.
  modport master (
    output dec_valid, dec_pkt, rob_ready, rob_tag, alu_rs_ready, lsu_rs_ready,
    input  dec_ready, rob_alloc, alu_rs_valid, lsu_rs_valid, disp_pkt, disp_tag
  );

  // Scheduler side.
  modport slave (
    input  dec_valid, dec_pkt, rob_ready, rob_tag, alu_rs_ready, lsu_rs_ready,
    output dec_ready, rob_alloc, alu_rs_valid, lsu_rs_valid, disp_pkt, disp_tag
  );
endinterface

// File: rtl/dispatch_fifo.sv
// rtl/dispatch_fifo.sv - in-order packet queue with wrapping pointers and occupancy
module dispatch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int PKT_W = 68,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [PKT_W-1:0] push_data,
  output logic [PKT_W-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two; flush empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/dispatch_scheduler.sv
// rtl/dispatch_scheduler.sv - in-order single-issue dispatch to ALU/LSU stations
module dispatch_scheduler
  import dispatch_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int PKT_W = dispatch_pkg::PKT_W,
  parameter  int TAG_W = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  dispatch_scheduler_if.slave  bus,
  output logic [CNT_W-1:0]     q_count,
  output logic [15:0]          stall_cnt
);

  logic             accept;
  logic             fire;
  logic             is_lsu;
  logic             tgt_ready;
  logic [PKT_W-1:0] head_pkt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  disp_state_t      state_q;
  disp_state_t      state_d;

  dispatch_fifo #(
    .DEPTH (DEPTH),
    .PKT_W (PKT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (accept),
    .pop       (fire),
    .push_data (bus.dec_pkt),
    .head_data (head_pkt),
    .count     (count)
  );

  assign is_lsu    = (classify(head_pkt[MEMREAD_BIT], head_pkt[MEMWRITE_BIT]) == RS_LSU);
  assign tgt_ready = is_lsu ? bus.lsu_rs_ready : bus.alu_rs_ready;

  // A full queue refuses decode even if the head leaves this cycle (no bypass).
  assign bus.dec_ready = (state_q != ST_FULL) & ~flush & ~rst;
  assign accept        = bus.dec_valid & bus.dec_ready;
  assign fire          = (state_q != ST_EMPTY) & bus.rob_ready & tgt_ready & ~flush;

  // Occupancy state follows the count the queue will hold after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next count/state and the combinational dispatch outputs.
  always_comb begin
    next_count       = count;
    state_d          = ST_ACTIVE;
    bus.rob_alloc    = fire;
    bus.alu_rs_valid = fire & ~is_lsu;
    bus.lsu_rs_valid = fire & is_lsu;
    bus.disp_pkt     = head_pkt;
    bus.disp_tag     = bus.rob_tag;
    if (flush) begin
      next_count = '0;
    end else begin
      case ({accept, fire})
        2'b10:   next_count = count + 1'b1;
        2'b01:   next_count = count - 1'b1;
        default: next_count = count;
      endcase
    end
    if (next_count == '0)                 state_d = ST_EMPTY;
    else if (next_count == CNT_W'(DEPTH)) state_d = ST_FULL;
  end

  // Count cycles where a queued head could not leave; survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state_q != ST_EMPTY) && !fire && !flush && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign q_count = count;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb/tb_dispatch_scheduler.sv - scoreboard bench for dispatch_scheduler
module tb_dispatch_scheduler;
  localparam int DEPTH = 4;
  localparam int PKT_W = 68;
  localparam int TAG_W = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ADD    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct {
    logic [PKT_W-1:0] pkt;
    logic             lsu;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  q_count;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [15:0] exp_stall = 16'd0;
  int n_accept = 0;
  int n_fire = 0;

  logic exp_ready, exp_fire, exp_lsu;
  int   sz;
  exp_t ent;

  dispatch_scheduler_if #(.PKT_W(PKT_W), .TAG_W(TAG_W)) bus();

  dispatch_scheduler #(.DEPTH(DEPTH), .PKT_W(PKT_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .q_count   (q_count),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bus.rob_tag = TAG_W'($urandom);
  end

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [6:0] opc, input logic mr,
                                               input logic mw, input logic [31:0] imm);
    return {opc, imm[2:0], imm[9:3], imm[14:10], imm[19:15], imm[24:20], imm,
            1'b1, ~mw, mr, mw};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_stall = 16'd0;
    end else begin
      sz        = sb.size();
      exp_ready = (sz < DEPTH) && !flush;
      exp_lsu   = 1'b0;
      exp_fire  = 1'b0;
      if (sz != 0) begin
        exp_lsu  = sb[0].lsu;
        exp_fire = bus.rob_ready && (exp_lsu ? bus.lsu_rs_ready : bus.alu_rs_ready) && !flush;
      end
      checks++;
      if (int'(q_count) != sz) begin
        errors++; $display("FAIL q_count got=%0d exp=%0d t=%0t", q_count, sz, $time);
      end
      checks++;
      if (bus.dec_ready !== exp_ready) begin
        errors++; $display("FAIL dec_ready got=%b exp=%b t=%0t", bus.dec_ready, exp_ready, $time);
      end
      checks++;
      if (bus.rob_alloc !== exp_fire) begin
        errors++; $display("FAIL rob_alloc got=%b exp=%b t=%0t", bus.rob_alloc, exp_fire, $time);
      end
      checks++;
      if (bus.alu_rs_valid !== (exp_fire && !exp_lsu)) begin
        errors++; $display("FAIL alu_rs_valid got=%b exp=%b t=%0t", bus.alu_rs_valid, exp_fire && !exp_lsu, $time);
      end
      checks++;
      if (bus.lsu_rs_valid !== (exp_fire && exp_lsu)) begin
        errors++; $display("FAIL lsu_rs_valid got=%b exp=%b t=%0t", bus.lsu_rs_valid, exp_fire && exp_lsu, $time);
      end
      checks++;
      if (bus.disp_tag !== bus.rob_tag) begin
        errors++; $display("FAIL disp_tag got=%h exp=%h t=%0t", bus.disp_tag, bus.rob_tag, $time);
      end
      checks++;
      if (stall_cnt !== exp_stall) begin
        errors++; $display("FAIL stall_cnt got=%0d exp=%0d t=%0t", stall_cnt, exp_stall, $time);
      end
      if (sz != 0) begin
        checks++;
        if (bus.disp_pkt !== sb[0].pkt) begin
          errors++; $display("FAIL disp_pkt got=%h exp=%h t=%0t", bus.disp_pkt, sb[0].pkt, $time);
        end
      end
      if (sz != 0 && !exp_fire && !flush && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (flush) begin
        sb.delete();
      end else begin
        if (exp_fire) begin
          ent = sb.pop_front();
          n_fire++;
        end
        if (bus.dec_valid && exp_ready) begin
          ent.pkt = bus.dec_pkt;
          ent.lsu = bus.dec_pkt[1] | bus.dec_pkt[0];
          sb.push_back(ent);
          n_accept++;
        end
      end
    end
  end

  task automatic drain(output bit ok);
    ok = 1'b0;
    bus.dec_valid    = 1'b0;
    bus.rob_ready    = 1'b1;
    bus.alu_rs_ready = 1'b1;
    bus.lsu_rs_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    cycle();
  endtask

  task automatic test_reset();
    bus.dec_valid    = 1'b0;
    bus.dec_pkt      = '0;
    bus.rob_ready    = 1'b0;
    bus.rob_tag      = '0;
    bus.alu_rs_ready = 1'b0;
    bus.lsu_rs_ready = 1'b0;
    #1;
    checks++;
    if (q_count !== 3'd0) begin errors++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
    checks++;
    if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL reset_dec_ready got=%b exp=0", bus.dec_ready); end
    checks++;
    if ({bus.rob_alloc, bus.alu_rs_valid, bus.lsu_rs_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_valids got=%b exp=000", {bus.rob_alloc, bus.alu_rs_valid, bus.lsu_rs_valid});
    end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_routing();
    logic [PKT_W-1:0] p_ld, p_add;
    p_ld  = mk_pkt(OP_LOAD, 1'b1, 1'b0, 32'h0000_1111);
    p_add = mk_pkt(OP_ADD, 1'b0, 1'b0, 32'h0000_2222);
    cycle();
    bus.rob_ready = 1'b1; bus.alu_rs_ready = 1'b1; bus.lsu_rs_ready = 1'b1;
    bus.dec_valid = 1'b1; bus.dec_pkt = p_ld;
    cycle();
    bus.dec_pkt = p_add;
    @(negedge clk);
    checks++;
    if (bus.lsu_rs_valid !== 1'b1 || bus.alu_rs_valid !== 1'b0) begin
      errors++; $display("FAIL route_load lsu=%b alu=%b exp lsu=1 alu=0", bus.lsu_rs_valid, bus.alu_rs_valid);
    end
    checks++;
    if (bus.disp_pkt !== p_ld) begin errors++; $display("FAIL route_load_pkt got=%h exp=%h", bus.disp_pkt, p_ld); end
    cycle();
    bus.dec_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.alu_rs_valid !== 1'b1 || bus.lsu_rs_valid !== 1'b0) begin
      errors++; $display("FAIL route_add alu=%b lsu=%b exp alu=1 lsu=0", bus.alu_rs_valid, bus.lsu_rs_valid);
    end
    checks++;
    if (bus.disp_pkt !== p_add) begin errors++; $display("FAIL route_add_pkt got=%h exp=%h", bus.disp_pkt, p_add); end
    cycle();
  endtask

  task automatic test_full();
    int  acc0, fire0;
    bit  ok;
    acc0 = n_accept; fire0 = n_fire;
    bus.rob_ready = 1'b0; bus.alu_rs_ready = 1'b1; bus.lsu_rs_ready = 1'b1;
    bus.dec_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.dec_pkt = (i % 2 == 0) ? mk_pkt(OP_STORE, 1'b0, 1'b1, 32'h100 + i)
                                 : mk_pkt(OP_ADD, 1'b0, 1'b0, 32'h100 + i);
      cycle();
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.dec_ready !== 1'b0 || q_count !== 3'd4) begin
      errors++; $display("FAIL full_state dec_ready=%b q_count=%0d exp 0/4", bus.dec_ready, q_count);
    end
    checks++;
    if (n_accept - acc0 != 4) begin errors++; $display("FAIL full_accepts got=%0d exp=4", n_accept - acc0); end
    cycle();
    drain(ok);
    checks++;
    if (!ok || n_fire - fire0 != 4) begin
      errors++; $display("FAIL full_drain done=%b fired=%0d exp=4", ok, n_fire - fire0);
    end
  endtask

  task automatic test_hol();
    int fire0;
    bit ok;
    fire0 = n_fire;
    bus.rob_ready = 1'b1; bus.alu_rs_ready = 1'b1; bus.lsu_rs_ready = 1'b0;
    bus.dec_valid = 1'b1; bus.dec_pkt = mk_pkt(OP_STORE, 1'b0, 1'b1, 32'hAAA);
    cycle();
    bus.dec_pkt = mk_pkt(OP_BRANCH, 1'b0, 1'b0, 32'hBBB);
    cycle();
    bus.dec_valid = 1'b0;
    repeat (3) cycle();
    @(negedge clk);
    checks++;
    if (bus.rob_alloc !== 1'b0 || q_count !== 3'd2) begin
      errors++; $display("FAIL hol_blocked rob_alloc=%b q_count=%0d exp 0/2", bus.rob_alloc, q_count);
    end
    cycle();
    bus.lsu_rs_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.lsu_rs_valid !== 1'b1) begin errors++; $display("FAIL hol_release lsu=%b exp=1", bus.lsu_rs_valid); end
    cycle();
    @(negedge clk);
    checks++;
    if (bus.alu_rs_valid !== 1'b1) begin errors++; $display("FAIL hol_younger alu=%b exp=1", bus.alu_rs_valid); end
    cycle();
    drain(ok);
    checks++;
    if (!ok || n_fire - fire0 != 2) begin
      errors++; $display("FAIL hol_count done=%b fired=%0d exp=2", ok, n_fire - fire0);
    end
  endtask

  task automatic test_flush();
    bus.rob_ready = 1'b0; bus.alu_rs_ready = 1'b1; bus.lsu_rs_ready = 1'b1;
    bus.dec_valid = 1'b1; bus.dec_pkt = mk_pkt(OP_ADD, 1'b0, 1'b0, 32'h31);
    cycle();
    bus.dec_pkt = mk_pkt(OP_LOAD, 1'b1, 1'b0, 32'h32);
    cycle();
    flush = 1'b1; bus.rob_ready = 1'b1;
    bus.dec_pkt = mk_pkt(OP_ADD, 1'b0, 1'b0, 32'h33);
    @(negedge clk);
    checks++;
    if (bus.rob_alloc !== 1'b0 || bus.dec_ready !== 1'b0) begin
      errors++; $display("FAIL flush_cycle rob_alloc=%b dec_ready=%b exp 0/0", bus.rob_alloc, bus.dec_ready);
    end
    cycle();
    flush = 1'b0; bus.dec_valid = 1'b0;
    checks++;
    if (q_count !== 3'd0 || dut.state_q !== dispatch_pkg::ST_EMPTY) begin
      errors++; $display("FAIL flush_after q_count=%0d state=%0d exp 0/EMPTY", q_count, dut.state_q);
    end
    cycle();
  endtask

  task automatic test_wrap();
    int acc0, fire0, idx;
    bit ok;
    acc0 = n_accept; fire0 = n_fire; idx = 0;
    bus.dec_valid = 1'b1;
    bus.dec_pkt   = mk_pkt(OP_ADD, 1'b0, 1'b0, 32'h500);
    for (int c = 0; c < 300 && idx < 10; c++) begin
      bus.rob_ready    = 1'($urandom_range(0, 1));
      bus.alu_rs_ready = 1'($urandom_range(0, 1));
      bus.lsu_rs_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      if (n_accept - acc0 > idx) idx++;
      cycle();
      if (idx < 10) begin
        if ($urandom_range(0, 1) == 1)
          bus.dec_pkt = mk_pkt(OP_LOAD, 1'b1, 1'b0, 32'h500 + idx);
        else
          bus.dec_pkt = mk_pkt(OP_ADD, 1'b0, 1'b0, 32'h500 + idx);
      end else begin
        bus.dec_valid = 1'b0;
      end
    end
    drain(ok);
    checks++;
    if (n_accept - acc0 != 10) begin errors++; $display("FAIL wrap_accepts got=%0d exp=10", n_accept - acc0); end
    checks++;
    if (!ok || n_fire - fire0 != 10) begin
      errors++; $display("FAIL wrap_fires done=%b got=%0d exp=10", ok, n_fire - fire0);
    end
  endtask

  task automatic test_reset_mid();
    bus.rob_ready = 1'b0; bus.alu_rs_ready = 1'b1; bus.lsu_rs_ready = 1'b1;
    bus.dec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.dec_pkt = mk_pkt(OP_ADD, 1'b0, 1'b0, 32'h700 + i);
      cycle();
    end
    bus.dec_valid = 1'b0;
    bus.rob_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (q_count !== 3'd0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL midrst_state q_count=%0d stall=%0d exp 0/0", q_count, stall_cnt);
    end
    checks++;
    if ({bus.rob_alloc, bus.alu_rs_valid, bus.lsu_rs_valid, bus.dec_ready} !== 4'b0000) begin
      errors++; $display("FAIL midrst_outputs got=%b exp=0000",
                         {bus.rob_alloc, bus.alu_rs_valid, bus.lsu_rs_valid, bus.dec_ready});
    end
    sb.delete();
    exp_stall = 16'd0;
    #1;
    rst = 1'b0;
    cycle();
    checks++;
    if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", bus.dec_ready); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_full();
    test_hol();
    test_flush();
    test_wrap();
    test_reset_mid();
    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
